// File: rtl/dcache_wb_assoc.sv
// dcache_wb_assoc: write-back, write-allocate data cache with 1- or 2-way associativity.
// Loads that hit return data combinationally. Stores that hit merge byte, half or word lanes
// on the next clock edge. A miss evicts the LRU victim: a dirty victim is first written
// back word by word, then the line is refilled word by word and committed in one cycle.
// The held request then completes as a hit.
// Ports:
//   clk, rst (async, active low)
//   cpu_data_req/wr, load_store, cpu_data_addr, cpu_data_wdata -> cpu_data_rdata, cpu_stall
//   mem_req/wr, mem_addr, mem_wdata -> external memory; mem_ack, mem_rdata <- memory
module dcache_wb_assoc #(
  parameter int INDEX_WIDTH     = 6,
  parameter int LINE_WORDS_LOG2 = 2,
  parameter int WAYS            = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_data_req,
  input  logic        cpu_data_wr,
  input  logic [2:0]  load_store,
  input  logic [31:0] cpu_data_addr,
  input  logic [31:0] cpu_data_wdata,
  output logic [31:0] cpu_data_rdata,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  localparam int SETS    = 1 << INDEX_WIDTH;
  localparam int WORDS   = 1 << LINE_WORDS_LOG2;
  localparam int OFF_W   = LINE_WORDS_LOG2 + 2;
  localparam int TAG_W   = 32 - INDEX_WIDTH - OFF_W;
  localparam int LINE_AW = INDEX_WIDTH + LINE_WORDS_LOG2;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] REFILL    = 2'd2;
  localparam logic [1:0] COMMIT    = 2'd3;

  logic [1:0]                 state;
  logic [LINE_WORDS_LOG2-1:0] cnt;
  logic                       victim_q;
  logic [TAG_W-1:0]           req_tag;
  logic [INDEX_WIDTH-1:0]     req_idx;

  logic [31:0]      data_arr [WAYS][SETS*WORDS];
  logic [TAG_W-1:0] tag_arr  [WAYS][SETS];
  logic [WAYS-1:0][SETS-1:0] valid, dirty;
  logic [SETS-1:0]  lru;

  logic [TAG_W-1:0]           tag;
  logic [INDEX_WIDTH-1:0]     idx;
  logic [LINE_WORDS_LOG2-1:0] word;
  assign tag  = cpu_data_addr[31 -: TAG_W];
  assign idx  = cpu_data_addr[OFF_W +: INDEX_WIDTH];
  assign word = cpu_data_addr[2 +: LINE_WORDS_LOG2];

  logic [WAYS-1:0] way_hit;
  logic            hit, miss, hit_way, victim;
  logic [3:0]      be, wr_be;
  logic [31:0]     st_data, wr_data;
  logic            wr_en, wr_way, refill_wr;
  logic [LINE_AW-1:0] wr_addr;

  always_comb begin
    way_hit = '0;
    for (int w = 0; w < WAYS; w++)
      way_hit[w] = valid[w][idx] && (tag_arr[w][idx] == tag);
    hit     = cpu_data_req && (|way_hit);
    miss    = cpu_data_req && !hit;
    hit_way = (WAYS == 2) ? way_hit[WAYS-1] : 1'b0;
    victim  = (WAYS == 2) ? lru[idx] : 1'b0;
    cpu_data_rdata = hit ? data_arr[hit_way][{idx, word}] : 32'h0;
    cpu_stall = (state != IDLE) || miss;
  end

  // Store lane enables; data is replicated so every enabled lane sees the right bytes.
  always_comb begin
    be      = 4'h0;
    st_data = cpu_data_wdata;
    case (load_store)
      3'b101: begin be = 4'b0001 << cpu_data_addr[1:0]; st_data = {4{cpu_data_wdata[7:0]}}; end
      3'b110: begin be = cpu_data_addr[1] ? 4'b1100 : 4'b0011; st_data = {2{cpu_data_wdata[15:0]}}; end
      3'b111: be = 4'hF;
      default: be = 4'h0;
    endcase
  end

  // Single data write port shared by store hits and refill beats (never in the same cycle).
  always_comb begin
    refill_wr = (state == REFILL) && mem_req && mem_ack;
    wr_en     = refill_wr || ((state == IDLE) && hit && cpu_data_wr && (|be));
    wr_way    = refill_wr ? victim_q : hit_way;
    wr_addr   = refill_wr ? {req_idx, cnt} : {idx, word};
    wr_be     = refill_wr ? 4'hF : be;
    wr_data   = refill_wr ? mem_rdata : st_data;
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      for (int b = 0; b < 4; b++)
        if (wr_be[b]) data_arr[wr_way][wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
    if (state == COMMIT) tag_arr[victim_q][req_idx] <= req_tag;
  end

  logic [TAG_W-1:0] vic_tag;
  logic [31:0]      vic_word;
  assign vic_tag  = tag_arr[victim_q][req_idx];
  assign vic_word = data_arr[victim_q][{req_idx, cnt}];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      victim_q  <= 1'b0;
      req_tag   <= '0;
      req_idx   <= '0;
      valid     <= '0;
      dirty     <= '0;
      lru       <= '0;
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            lru[idx] <= ~hit_way;
            if (cpu_data_wr && (|be)) dirty[hit_way][idx] <= 1'b1;
          end else if (miss) begin
            // Line address is latched so the miss completes even if the request drops.
            victim_q <= victim;
            req_tag  <= tag;
            req_idx  <= idx;
            cnt      <= '0;
            // Victim goes invalid now so a half-refilled line can never hit.
            valid[victim][idx] <= 1'b0;
            state <= (valid[victim][idx] && dirty[victim][idx]) ? WRITEBACK : REFILL;
          end
        end
        WRITEBACK, REFILL: begin
          // One request per word; mem_req drops for a cycle after each ack.
          if (!mem_req) begin
            mem_req   <= 1'b1;
            mem_wr    <= (state == WRITEBACK);
            mem_addr  <= {(state == WRITEBACK) ? vic_tag : req_tag, req_idx, cnt, 2'b00};
            mem_wdata <= (state == WRITEBACK) ? vic_word : 32'h0;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            mem_wr  <= 1'b0;
            cnt     <= cnt + 1'b1;
            if (&cnt) state <= (state == WRITEBACK) ? REFILL : COMMIT;
          end
        end
        COMMIT: begin
          valid[victim_q][req_idx] <= 1'b1;
          dirty[victim_q][req_idx] <= 1'b0;
          lru[req_idx]             <= ~victim_q;
          state                    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_wb_assoc.sv
// Bench for dcache_wb_assoc: directed scenarios plus random accesses, checked against a
// line-level cache model and a sparse memory model with a 2-cycle ack responder.
module tb_dcache_wb_assoc;
  logic        clk = 1'b0, rst = 1'b0;
  logic        cpu_data_req = 1'b0, cpu_data_wr = 1'b0;
  logic [2:0]  load_store = 3'b111;
  logic [31:0] cpu_data_addr = '0, cpu_data_wdata = '0;
  logic [31:0] cpu_data_rdata;
  logic        cpu_stall, mem_req, mem_wr, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        resp_ack, stray_ack = 1'b0;

  assign mem_ack = resp_ack | stray_ack;
  always #5 clk = ~clk;

  dcache_wb_assoc dut (
    .clk(clk), .rst(rst), .cpu_data_req(cpu_data_req), .cpu_data_wr(cpu_data_wr),
    .load_store(load_store), .cpu_data_addr(cpu_data_addr), .cpu_data_wdata(cpu_data_wdata),
    .cpu_data_rdata(cpu_data_rdata), .cpu_stall(cpu_stall), .mem_req(mem_req),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  int n_tests = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Sparse backing memory; untouched words have an address-derived value.
  logic [31:0] mem_store [logic [31:0]];
  function automatic logic [31:0] mem_get(input logic [31:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  typedef struct { logic [31:0] addr; logic wr; logic [31:0] data; } xfer_t;
  xfer_t log_q[$];

  int wcnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_ack <= 1'b0;
      wcnt     <= 0;
    end else begin
      resp_ack <= 1'b0;
      if (mem_req && !resp_ack) begin
        if (wcnt == 1) begin
          resp_ack <= 1'b1;
          wcnt     <= 0;
          if (mem_wr) mem_store[mem_addr] = mem_wdata;
          else        mem_rdata <= mem_get(mem_addr);
          log_q.push_back('{mem_addr, mem_wr, mem_wdata});
        end else wcnt <= wcnt + 1;
      end
    end
  end

  // Line-level reference: 64 sets x 2 ways x 4 words, one victim pointer per set.
  logic [21:0] m_tag [64][2];
  bit          m_val [64][2];
  bit          m_dty [64][2];
  bit          m_lru [64];
  logic [31:0] m_dat [64][2][4];

  task automatic model_reset();
    for (int s = 0; s < 64; s++) begin
      m_lru[s] = 0;
      for (int w = 0; w < 2; w++) begin m_val[s][w] = 0; m_dty[s][w] = 0; end
    end
  endtask

  task automatic access(input bit wr, input logic [2:0] ls, input logic [31:0] a,
                        input logic [31:0] wd);
    logic [5:0]  s;
    logic [1:0]  wo;
    logic [21:0] t;
    logic [31:0] la;
    logic [31:0] fill [4];
    bit hit;
    int way, v, cyc, n;
    xfer_t exp_q[$];
    s = a[9:4]; wo = a[3:2]; t = a[31:10];
    hit = 0; way = 0;
    for (int w = 0; w < 2; w++)
      if (m_val[s][w] && m_tag[s][w] == t) begin hit = 1; way = w; end
    @(negedge clk);
    cpu_data_req = 1'b1; cpu_data_wr = wr; load_store = ls;
    cpu_data_addr = a; cpu_data_wdata = wd;
    #1;
    chk("stall", {31'b0, cpu_stall}, {31'b0, !hit});
    if (!hit) begin
      chk("rdata_miss", cpu_data_rdata, 32'h0);
      v = m_lru[s];
      exp_q = {};
      if (m_val[s][v] && m_dty[s][v])
        for (int k = 0; k < 4; k++) begin
          la = {m_tag[s][v], s, k[1:0], 2'b00};
          exp_q.push_back('{la, 1'b1, m_dat[s][v][k]});
        end
      for (int k = 0; k < 4; k++) begin
        la = {t, s, k[1:0], 2'b00};
        fill[k] = mem_get(la);
        exp_q.push_back('{la, 1'b0, fill[k]});
      end
      log_q = {};
      cyc = 0;
      while (cpu_stall && cyc < 300) begin @(posedge clk); #2; cyc++; end
      chk("miss_done", {31'b0, cpu_stall}, 32'h0);
      chk("xfer_cnt", log_q.size(), exp_q.size());
      n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
        chk("xfer_addr", log_q[i].addr, exp_q[i].addr);
        chk("xfer_wr", {31'b0, log_q[i].wr}, {31'b0, exp_q[i].wr});
        if (exp_q[i].wr) chk("wb_data", log_q[i].data, exp_q[i].data);
      end
      m_val[s][v] = 1; m_dty[s][v] = 0; m_tag[s][v] = t;
      for (int k = 0; k < 4; k++) m_dat[s][v][k] = fill[k];
      way = v;
    end
    chk("mem_req_quiet", {31'b0, mem_req}, 32'h0);
    if (!wr) chk("rdata", cpu_data_rdata, m_dat[s][way][wo]);
    m_lru[s] = (way == 0);
    if (wr) begin
      case (ls)
        3'b101: begin m_dat[s][way][wo][8*a[1:0] +: 8] = wd[7:0];  m_dty[s][way] = 1; end
        3'b110: begin m_dat[s][way][wo][16*a[1] +: 16] = wd[15:0]; m_dty[s][way] = 1; end
        3'b111: begin m_dat[s][way][wo] = wd;                      m_dty[s][way] = 1; end
        default: ;
      endcase
    end
    @(posedge clk); #1;
    cpu_data_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=%0d exp=0", 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int cyc;
    logic [31:0] a;
    logic [2:0]  ls;
    model_reset();
    #1;
    chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_stall", {31'b0, cpu_stall}, 32'h0);
    chk("rst_rdata", cpu_data_rdata, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    access(0, 3'b111, 32'h0000_0100, 0);          // cold miss, 4 reads
    access(0, 3'b111, 32'h0000_0104, 0);          // hit, no traffic
    access(1, 3'b101, 32'h0000_0101, 32'hAB);     // sb
    access(0, 3'b111, 32'h0000_0100, 0);          // merged word
    access(0, 3'b111, 32'h0000_1100, 0);          // fills way1
    access(0, 3'b111, 32'h0000_2100, 0);          // evicts dirty way0

    // Reset in the middle of a refill burst.
    @(negedge clk);
    cpu_data_req = 1'b1; cpu_data_wr = 1'b0; cpu_data_addr = 32'h0000_3200;
    cyc = 0;
    while (!(mem_req && !mem_wr) && cyc < 200) begin @(posedge clk); #2; cyc++; end
    chk("refill_seen", {31'b0, mem_req & !mem_wr}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_mem_req", {31'b0, mem_req}, 32'h0);
    cpu_data_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    access(0, 3'b111, 32'h0000_3200, 0);          // must refetch
    access(0, 3'b111, 32'h0000_0100, 0);          // earlier line gone too

    // Stray ack while idle.
    @(negedge clk);
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    #1;
    chk("stray_mem_req", {31'b0, mem_req}, 32'h0);
    chk("stray_stall", {31'b0, cpu_stall}, 32'h0);
    access(0, 3'b111, 32'h0000_3204, 0);

    for (int i = 0; i < 200; i++) begin
      a = {20'h0, $urandom_range(0, 3) == 0 ? 2'd0 : 2'($urandom_range(0, 3)),
           6'($urandom_range(0, 3)), 4'($urandom)};
      case ($urandom_range(0, 9))
        0:       ls = 3'b000;
        1, 2, 3: ls = 3'b101;
        4, 5, 6: ls = 3'b110;
        default: ls = 3'b111;
      endcase
      access($urandom_range(0, 1) == 1, ls, a, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
